// File: rtl/program_loader_arbiter.sv
// Boot loader and instruction-RAM arbiter: streams a header plus little-endian words into RAM,
// then hands the RAM port to the core fetch path. Define LOADER_CHECKSUM_EN to require a trailing checksum byte.
module program_loader_arbiter #(
  parameter int MEMORY_DEPTH = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_BITS    = $clog2(MEMORY_DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [7:0]            byte_i,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  input  logic [DATA_WIDTH-1:0] cpu_fetch_addr_i,
  output logic [DATA_WIDTH-1:0] cpu_instruction_o,
  output logic                  cpu_hold_o,
  output logic                  mem_we_o,
  output logic [ADDR_BITS-1:0]  mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  load_done_o,
  output logic                  error_o
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, WRITE, CHK, RUN, ERROR} state_t;
`else
  typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, WRITE, RUN, ERROR} state_t;
`endif

  state_t                state_q;
  logic [15:0]           len_q;
  logic [ADDR_BITS-1:0]  idx_q;
  logic [1:0]            byteCnt_q;
  logic [DATA_WIDTH-1:0] word_q;
  logic [15:0]           hdrCount_d;
  logic [15:0]           idxNext_d;
  logic                  accept;
  logic                  unusedFetch;

  assign accept     = byte_valid_i && byte_ready_o;
  assign hdrCount_d = {byte_i, len_q[7:0]};
  assign idxNext_d  = 16'(idx_q) + 16'd1;

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] sum_q;
  logic [7:0] sumCheck_d;
  assign sumCheck_d = sum_q + byte_i;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      len_q     <= '0;
      idx_q     <= '0;
      byteCnt_q <= '0;
      word_q    <= '0;
`ifdef LOADER_CHECKSUM_EN
      sum_q     <= '0;
`endif
    end else begin
      case (state_q)
        IDLE, RUN, ERROR: begin
          if (start_i) begin
            state_q <= HDR0;
`ifdef LOADER_CHECKSUM_EN
            sum_q   <= '0;
`endif
          end
        end
        HDR0: begin
          if (accept) begin
            len_q[7:0] <= byte_i;
            state_q    <= HDR1;
          end
        end
        HDR1: begin
          if (accept) begin
            len_q[15:8] <= byte_i;
            idx_q       <= '0;
            byteCnt_q   <= '0;
            if (hdrCount_d == 16'd0 || hdrCount_d > 16'(MEMORY_DEPTH))
              state_q <= ERROR;
            else
              state_q <= DATA;
          end
        end
        DATA: begin
          if (accept) begin
            word_q[{byteCnt_q, 3'b000} +: 8] <= byte_i;
            byteCnt_q <= byteCnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            sum_q     <= sumCheck_d;
`endif
            if (byteCnt_q == 2'd3) state_q <= WRITE;
          end
        end
        WRITE: begin
          idx_q <= idx_q + 1'b1;
          if (idxNext_d == len_q) begin
`ifdef LOADER_CHECKSUM_EN
            state_q <= CHK;
`else
            state_q <= RUN;
`endif
          end else begin
            state_q <= DATA;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHK: begin
          if (accept) state_q <= (sumCheck_d == 8'h00) ? RUN : ERROR;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs are pure decodes of the state register, except the RUN-time fetch path which must be zero-latency.
`ifdef LOADER_CHECKSUM_EN
  assign byte_ready_o = (state_q == HDR0) || (state_q == HDR1) || (state_q == DATA) || (state_q == CHK);
`else
  assign byte_ready_o = (state_q == HDR0) || (state_q == HDR1) || (state_q == DATA);
`endif
  assign cpu_hold_o        = (state_q != RUN);
  assign load_done_o       = (state_q == RUN);
  assign error_o           = (state_q == ERROR);
  assign mem_we_o          = (state_q == WRITE);
  assign mem_wdata_o       = word_q;
  assign mem_addr_o        = (state_q == RUN) ? cpu_fetch_addr_i[ADDR_BITS+1:2] : idx_q;
  assign cpu_instruction_o = (state_q == RUN) ? mem_rdata_i : DATA_WIDTH'(32'h0000_0013);

  assign unusedFetch = ^{cpu_fetch_addr_i[DATA_WIDTH-1:ADDR_BITS+2], cpu_fetch_addr_i[1:0]};

endmodule
